// File: rtl/regdump_pkg.sv
// -----------------------------------------------------------------------------
// regdump_pkg
// Shared types and helpers for the register-file dump reader.
//   state_t   : dump sequencer states (IDLE, FETCH, SEND, CSUM)
//   ptr_width : width of the walk pointer, one bit wider than the address so
//               that the value DEPTH (end of walk) is representable.
// Optional feature: REGDUMP_CHECKSUM_EN (consumed by regfile_dump_reader).
// -----------------------------------------------------------------------------
package regdump_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      CSUM  = 2'd3
   } state_t;

   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/regdump_xor_acc.sv
// -----------------------------------------------------------------------------
// regdump_xor_acc
// Running XOR accumulator used to build the optional dump checksum word.
// Ports:
//   clk     in   clock, posedge
//   rst_n   in   asynchronous active-low reset, clears the accumulator
//   clear   in   synchronous clear (takes priority over enable)
//   enable  in   fold din into the accumulator this cycle
//   din     in   WIDTH data to fold in
//   acc     out  WIDTH accumulated XOR value
// Instantiated only when REGDUMP_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module regdump_xor_acc
   import regdump_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] acc
);

   logic [WIDTH-1:0] acc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg <= '0;
      end else if (clear) begin
         acc_reg <= '0;
      end else if (enable) begin
         acc_reg <= acc_reg ^ din;
      end
   end

   assign acc = acc_reg;

endmodule

// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
// Walks every entry of an attached register array through its combinational
// read port after a start pulse and streams the words out on a valid/ready
// interface, one word per cycle while the sink is ready.
// Ports:
//   clk      in   clock, posedge
//   rst_n    in   asynchronous active-low reset
//   start    in   one-cycle dump request, ignored while busy
//   busy     out  high while a dump is in progress
//   done     out  one-cycle pulse after the final word's handshake
//   rd_addr  out  read address to the register array
//   rd_data  in   combinational read data for rd_addr
//   m_valid  out  output word valid
//   m_ready  in   sink ready
//   m_data   out  output word
//   m_addr   out  source index of m_data (0 for the checksum word)
//   m_last   out  final word of the dump
// Optional feature: define REGDUMP_CHECKSUM_EN to append an XOR checksum of
// all DEPTH words as one extra word (m_last=1, m_addr=0).
// -----------------------------------------------------------------------------
module regfile_dump_reader
   import regdump_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH)-1:0] rd_addr,
   input  logic [WIDTH-1:0]         rd_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [WIDTH-1:0]         m_data,
   output logic [$clog2(DEPTH)-1:0] m_addr,
   output logic                     m_last
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_width(DEPTH);
   localparam logic [PW-1:0] PTR_END  = PW'(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
`ifdef REGDUMP_CHECKSUM_EN
   localparam logic CSUM_EN = 1'b1;
`else
   localparam logic CSUM_EN = 1'b0;
`endif

   state_t           state_reg,   state_next;
   logic [PW-1:0]    ptr_reg,     ptr_next;
   logic             m_valid_reg, m_valid_next;
   logic [WIDTH-1:0] m_data_reg,  m_data_next;
   logic [AW-1:0]    m_addr_reg,  m_addr_next;
   logic             m_last_reg,  m_last_next;
   logic             done_reg,    done_next;
   logic             load;        // capture rd_data into the output register

`ifdef REGDUMP_CHECKSUM_EN
   logic             acc_clear;
   logic [WIDTH-1:0] csum;

   // Cleared on the acceptance edge, then folds in each word as it is loaded,
   // so it always matches exactly what the sink received.
   assign acc_clear = (state_reg == IDLE) && start;

   regdump_xor_acc #(
      .WIDTH (WIDTH)
   ) u_xor_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (acc_clear),
      .enable (load),
      .din    (rd_data),
      .acc    (csum)
   );
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         ptr_reg     <= '0;
         m_valid_reg <= 1'b0;
         m_data_reg  <= '0;
         m_addr_reg  <= '0;
         m_last_reg  <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         m_valid_reg <= m_valid_next;
         m_data_reg  <= m_data_next;
         m_addr_reg  <= m_addr_next;
         m_last_reg  <= m_last_next;
         done_reg    <= done_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      ptr_next     = ptr_reg;
      m_valid_next = m_valid_reg;
      m_data_next  = m_data_reg;
      m_addr_next  = m_addr_reg;
      m_last_next  = m_last_reg;
      done_next    = 1'b0;
      load         = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               ptr_next   = '0;
               state_next = FETCH;
            end
         end

         FETCH: begin
            load       = 1'b1;
            state_next = SEND;
         end

         SEND: begin
            if (m_valid_reg && m_ready) begin
               if (ptr_reg != PTR_END) begin
                  // Back-to-back: the next word replaces the accepted one.
                  load = 1'b1;
               end else begin
`ifdef REGDUMP_CHECKSUM_EN
                  m_data_next = csum;
                  m_addr_next = '0;
                  m_last_next = 1'b1;
                  state_next  = CSUM;
`else
                  m_valid_next = 1'b0;
                  m_last_next  = 1'b0;
                  done_next    = 1'b1;
                  state_next   = IDLE;
`endif
               end
            end
         end

`ifdef REGDUMP_CHECKSUM_EN
         CSUM: begin
            if (m_valid_reg && m_ready) begin
               m_valid_next = 1'b0;
               m_last_next  = 1'b0;
               done_next    = 1'b1;
               state_next   = IDLE;
            end
         end
`endif

         default: begin
            state_next = IDLE;
         end
      endcase

      // The array is only read on a load, so a stalled word never re-reads
      // and later writes to an already-sent entry cannot leak into the stream.
      if (load) begin
         m_data_next  = rd_data;
         m_addr_next  = ptr_reg[AW-1:0];
         m_valid_next = 1'b1;
         m_last_next  = (ptr_reg == PTR_LAST) && !CSUM_EN;
         ptr_next     = ptr_reg + PW'(1);
      end
   end

   assign busy    = (state_reg != IDLE);
   assign done    = done_reg;
   assign rd_addr = ptr_reg[AW-1:0];
   assign m_valid = m_valid_reg;
   assign m_data  = m_data_reg;
   assign m_addr  = m_addr_reg;
   assign m_last  = m_last_reg;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_reader
// Bench for regfile_dump_reader (WIDTH=8, DEPTH=4) paired with a small
// register array. A phase/word-count model of the dump predicts every output
// each cycle; directed sequences pin the model with literal expectations, then
// a randomized phase mixes sink stalls, array writes, stray starts and resets.
// Honours REGDUMP_CHECKSUM_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_regfile_dump_reader;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int AW = $clog2(D);
`ifdef REGDUMP_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif
   localparam int NW = D + CS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          m_ready = 1'b0;
   logic          busy, done, m_valid, m_last;
   logic [AW-1:0] rd_addr, m_addr;
   logic [W-1:0]  rd_data, m_data;

   // Register array attached to the read port.
   logic [W-1:0]  mem [0:D-1];
   assign rd_data = mem[rd_addr];

   always #5 clk = ~clk;

   regfile_dump_reader #(
      .WIDTH (W),
      .DEPTH (D)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_addr  (m_addr),
      .m_last  (m_last)
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   // md_phase: 0 idle, 1 accepted but nothing presented yet, 2 presenting word md_idx
   int md_phase = 0;
   int md_idx   = 0;
   bit md_done  = 1'b0;
   int exp_w [0:D-1];

   function automatic int word_val(input int i);
      int x;
      if (i < D) return exp_w[i];
      x = 0;
      for (int k = 0; k < D; k++) x = x ^ exp_w[k];
      return x;
   endfunction

   // An array write reaches the stream only for entries not yet loaded.
   task automatic write_mem(input int j, input int v);
      mem[j] = W'(v);
      if (md_phase == 1 || (md_phase == 2 && md_idx < D && j > md_idx))
         exp_w[j] = v;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_m_valid", m_valid, 0);
         chk("rst_m_data", m_data, 0);
         chk("rst_m_addr", m_addr, 0);
         chk("rst_m_last", m_last, 0);
         chk("rst_rd_addr", rd_addr, 0);
         md_phase = 0;
         md_idx   = 0;
         md_done  = 1'b0;
      end else begin
         chk("busy", busy, 32'(md_phase != 0));
         chk("done", done, 32'(md_done));
         chk("m_valid", m_valid, 32'(md_phase == 2));
         if (md_phase == 2) begin
            chk($sformatf("m_data[%0d]", md_idx), m_data, word_val(md_idx));
            chk($sformatf("m_addr[%0d]", md_idx), m_addr, (md_idx < D) ? md_idx : 0);
            chk($sformatf("m_last[%0d]", md_idx), m_last, 32'(md_idx == NW - 1));
            if (md_idx + 1 < D) chk("rd_addr_next", rd_addr, md_idx + 1);
         end else if (md_phase == 1) begin
            chk("rd_addr_first", rd_addr, 0);
         end
         // advance to next cycle's expectation
         md_done = 1'b0;
         case (md_phase)
            0: if (start) begin
               md_phase = 1;
               for (int k = 0; k < D; k++) exp_w[k] = int'(mem[k]);
            end
            1: begin
               md_phase = 2;
               md_idx   = 0;
            end
            default: if (m_ready) begin
               if (md_idx == NW - 1) begin
                  md_phase = 0;
                  md_done  = 1'b1;
               end else begin
                  md_idx++;
               end
            end
         endcase
      end
   end

   // ---------------- stream capture ----------------
   logic [W-1:0]  cap_d [$];
   int            cap_a [$];
   bit            cap_l [$];
   int            n_done = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (m_valid && m_ready) begin
            cap_d.push_back(m_data);
            cap_a.push_back(int'(m_addr));
            cap_l.push_back(m_last);
         end
         if (done) n_done++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_cap();
      cap_d.delete();
      cap_a.delete();
      cap_l.delete();
   endtask

   task automatic load4(input int a, input int b, input int c, input int d);
      write_mem(0, a);
      write_mem(1, b);
      write_mem(2, c);
      write_mem(3, d);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget, output int cyc);
      cyc = 0;
      while (!done && cyc < budget) begin
         tick();
         cyc++;
      end
      chk({nm, "_done_seen"}, done, 1);
   endtask

   task automatic verify(input string nm, input int e0, input int e1, input int e2, input int e3);
      int e [4];
      int x;
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      x = e0 ^ e1 ^ e2 ^ e3;
      chk({nm, "_count"}, cap_d.size(), NW);
      for (int i = 0; i < NW && i < cap_d.size(); i++) begin
         chk($sformatf("%s_data%0d", nm, i), cap_d[i], (i < D) ? e[i] : x);
         chk($sformatf("%s_addr%0d", nm, i), cap_a[i], (i < D) ? i : 0);
         chk($sformatf("%s_last%0d", nm, i), cap_l[i], 32'(i == NW - 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int n0;
      bit seen;

      for (int k = 0; k < D; k++) mem[k] = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // ---- T1: basic dump at full throughput ----
      clear_cap();
      load4(8'h11, 8'h22, 8'h44, 8'h88);
      m_ready = 1'b1;
      n0 = n_done;
      pulse_start();
      wait_done("t1", 40, cyc);
      chk("t1_start_to_done", 1 + cyc, (CS != 0) ? 7 : 6);
      tick();
      chk("t1_done_width", done, 0);
      chk("t1_done_pulses", n_done - n0, 1);
      verify("t1", 8'h11, 8'h22, 8'h44, 8'h88);
`ifdef REGDUMP_CHECKSUM_EN
      chk("t1_csum_literal", cap_d[4], 8'hFF);
`endif

      // ---- T2: stall on word 1, writes during the stall ----
      clear_cap();
      load4(8'h11, 8'h22, 8'h44, 8'h88);
      pulse_start();
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (m_valid && m_addr == 1) seen = 1'b1;
         else tick();
      end
      chk("t2_reached_word1", seen, 1);
      m_ready = 1'b0;
      write_mem(3, 8'h99);   // not loaded yet: must appear
      write_mem(0, 8'h5A);   // already sent: must not appear
      write_mem(1, 8'h66);   // currently held: must not change
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("t2_hold_data", m_data, 8'h22);
         chk("t2_hold_addr", m_addr, 1);
         chk("t2_hold_last", m_last, 0);
      end
      m_ready = 1'b1;
      wait_done("t2", 40, cyc);
      tick();
      verify("t2", 8'h11, 8'h22, 8'h44, 8'h99);

      // ---- T3: start pulsed again during the dump ----
      clear_cap();
      load4(8'h01, 8'h02, 8'h03, 8'h04);
      n0 = n_done;
      pulse_start();
      tick();
      pulse_start();
      wait_done("t3", 40, cyc);
      for (int c = 0; c < 4; c++) tick();
      chk("t3_no_restart", busy, 0);
      chk("t3_done_pulses", n_done - n0, 1);
      verify("t3", 8'h01, 8'h02, 8'h03, 8'h04);

      // ---- T4: reset after the second handshake ----
      clear_cap();
      load4(8'hA1, 8'hB2, 8'hC3, 8'hD4);
      n0 = n_done;
      pulse_start();
      for (int c = 0; c < 20 && cap_d.size() < 2; c++) tick();
      chk("t4_two_handshakes", cap_d.size(), 2);
      rst_n = 1'b0;
      #1;
      chk("t4_busy", busy, 0);
      chk("t4_m_valid", m_valid, 0);
      chk("t4_m_data", m_data, 0);
      chk("t4_m_last", m_last, 0);
      chk("t4_m_addr", m_addr, 0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("t4_no_done", n_done - n0, 0);
      clear_cap();
      pulse_start();
      wait_done("t4b", 40, cyc);
      tick();
      verify("t4b", 8'hA1, 8'hB2, 8'hC3, 8'hD4);

      // ---- T5: randomized traffic checked by the model ----
      n0 = n_done;
      for (int c = 0; c < 800; c++) begin
         rst_n   = ($urandom_range(0, 199) != 0);
         start   = ($urandom_range(0, 5) == 0);
         m_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0)
            write_mem(int'($urandom_range(0, D - 1)), int'($urandom_range(0, 255)));
         tick();
      end
      rst_n   = 1'b1;
      start   = 1'b0;
      m_ready = 1'b1;
      for (int c = 0; c < 20; c++) tick();
      chk("t5_progress", 32'(n_done - n0 > 10), 1);
      chk("t5_idle_at_end", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
